// File: rtl/rs_aged.sv
// Age-matrix reservation station: CDB wakeup, oldest-ready-first issue per port,
// branch-mask squash on mispredict and mask clearing on correct prediction.
module rs_aged #(
    parameter  int RS_DEPTH = 16,
    parameter  int DISP_W   = 2,
    parameter  int CDB_W    = 2,
    parameter  int NUM_FU   = 4,
    parameter  int TAG_W    = 6,
    parameter  int BR_W     = 4,
    parameter  int PLD_W    = 64,
    localparam int FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int CNT_W    = $clog2(RS_DEPTH) + 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DISP_W-1:0]            disp_valid,
    input  logic [DISP_W-1:0][TAG_W-1:0] disp_tag1,
    input  logic [DISP_W-1:0][TAG_W-1:0] disp_tag2,
    input  logic [DISP_W-1:0]            disp_rdy1,
    input  logic [DISP_W-1:0]            disp_rdy2,
    input  logic [DISP_W-1:0][FU_W-1:0]  disp_fu,
    input  logic [DISP_W-1:0][BR_W-1:0]  disp_brmask,
    input  logic [DISP_W-1:0][PLD_W-1:0] disp_pld,
    input  logic [CDB_W-1:0]             cdb_valid,
    input  logic [CDB_W-1:0][TAG_W-1:0]  cdb_tag,
    input  logic [NUM_FU-1:0]            issue_stall,
    input  logic                         br_valid,
    input  logic [BR_W-1:0]              br_bit,
    input  logic                         br_mispred,
    output logic [NUM_FU-1:0]            issue_valid,
    output logic [NUM_FU-1:0][PLD_W-1:0] issue_pld,
    output logic [NUM_FU-1:0][BR_W-1:0]  issue_brmask,
    output logic [CNT_W-1:0]             free_cnt,
    output logic                         full,
    output logic                         disp_overflow
);
    localparam int LANE_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;

    logic [RS_DEPTH-1:0] busy_q, rdy1_q, rdy2_q;
    logic [TAG_W-1:0]    tag1_q     [RS_DEPTH];
    logic [TAG_W-1:0]    tag2_q     [RS_DEPTH];
    logic [FU_W-1:0]     fu_q       [RS_DEPTH];
    logic [BR_W-1:0]     brmask_q   [RS_DEPTH];
    logic [PLD_W-1:0]    pld_q      [RS_DEPTH];
    logic [RS_DEPTH-1:0] older_q    [RS_DEPTH];  // older_q[a][b]: entry a is older than entry b

    logic                br_squash;
    logic [BR_W-1:0]     clr_mask;
    logic [RS_DEPTH-1:0] squash, src_rdy1, src_rdy2, issued, survive;
    logic [BR_W-1:0]     brmask_eff [RS_DEPTH];
    logic [NUM_FU-1:0][RS_DEPTH-1:0] cand, grant;
    logic [RS_DEPTH-1:0] wr_en;
    logic [LANE_W-1:0]   wr_lane    [RS_DEPTH];
    logic                lane_ok, placed, overflow;

    function automatic logic cdb_hit(input logic [TAG_W-1:0]            tag,
                                     input logic [CDB_W-1:0]            vld,
                                     input logic [CDB_W-1:0][TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_W; c++)
            hit = hit | (vld[c] & (tags[c] == tag));
        return hit;
    endfunction

    assign br_squash = br_valid & br_mispred;
    assign clr_mask  = (br_valid & ~br_mispred) ? br_bit : '0;
    assign survive   = busy_q & ~squash & ~issued;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            squash[i]     = busy_q[i] & br_squash & (|(brmask_q[i] & br_bit));
            src_rdy1[i]   = rdy1_q[i] | cdb_hit(tag1_q[i], cdb_valid, cdb_tag);
            src_rdy2[i]   = rdy2_q[i] | cdb_hit(tag2_q[i], cdb_valid, cdb_tag);
            brmask_eff[i] = brmask_q[i] & ~clr_mask;
        end
    end

    // A candidate wins its port only if no older candidate for the same port exists.
    always_comb begin
        // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
        cand  = '0;
        grant = '0;
        for (int k = 0; k < NUM_FU; k++)
            for (int i = 0; i < RS_DEPTH; i++)
                cand[k][i] = reset & ~issue_stall[k] & busy_q[i] & ~squash[i] &
                             src_rdy1[i] & src_rdy2[i] & (fu_q[i] == FU_W'(k));
        for (int k = 0; k < NUM_FU; k++)
            for (int i = 0; i < RS_DEPTH; i++) begin
                grant[k][i] = cand[k][i];
                for (int j = 0; j < RS_DEPTH; j++)
                    if (older_q[j][i] && cand[k][j])
                        grant[k][i] = 1'b0;
            end
    end

    always_comb begin
        issued       = '0;
        issue_valid  = '0;
        issue_pld    = '0;
        issue_brmask = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            issue_valid[k] = |grant[k];
            issued         = issued | grant[k];
            for (int i = 0; i < RS_DEPTH; i++)
                if (grant[k][i]) begin
                    issue_pld[k]    = pld_q[i];
                    issue_brmask[k] = brmask_eff[i];
                end
        end
    end

    // Lanes take free slots lowest index first; slots vacated this cycle stay busy until the edge.
    always_comb begin
        wr_en    = '0;
        overflow = 1'b0;
        lane_ok  = 1'b0;
        placed   = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++)
            wr_lane[i] = '0;
        for (int l = 0; l < DISP_W; l++) begin
            lane_ok = disp_valid[l] & ~(br_squash & (|(disp_brmask[l] & br_bit)));
            placed  = 1'b0;
            for (int i = 0; i < RS_DEPTH; i++)
                if (lane_ok && !placed && !busy_q[i] && !wr_en[i]) begin
                    wr_en[i]   = 1'b1;
                    wr_lane[i] = LANE_W'(l);
                    placed     = 1'b1;
                end
            overflow = overflow | (lane_ok & ~placed);
        end
    end

    assign disp_overflow = reset & overflow;

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < RS_DEPTH; i++)
            if (!busy_q[i])
                free_cnt = free_cnt + CNT_W'(1);
    end

    assign full = (free_cnt == '0);

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            busy_q <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                brmask_q[i] <= '0;
                older_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (wr_en[i]) begin
                    busy_q[i]   <= 1'b1;
                    rdy1_q[i]   <= disp_rdy1[wr_lane[i]] | cdb_hit(disp_tag1[wr_lane[i]], cdb_valid, cdb_tag);
                    rdy2_q[i]   <= disp_rdy2[wr_lane[i]] | cdb_hit(disp_tag2[wr_lane[i]], cdb_valid, cdb_tag);
                    brmask_q[i] <= disp_brmask[wr_lane[i]] & ~clr_mask;
                    // NOTE: tags, port and payload are qualified by busy, so they carry no reset.
                    tag1_q[i]   <= disp_tag1[wr_lane[i]];
                    tag2_q[i]   <= disp_tag2[wr_lane[i]];
                    fu_q[i]     <= disp_fu[wr_lane[i]];
                    pld_q[i]    <= disp_pld[wr_lane[i]];
                end else begin
                    if (squash[i] || issued[i])
                        busy_q[i] <= 1'b0;
                    rdy1_q[i]   <= src_rdy1[i];
                    rdy2_q[i]   <= src_rdy2[i];
                    brmask_q[i] <= brmask_eff[i];
                end
                for (int x = 0; x < RS_DEPTH; x++)
                    if (wr_en[i])
                        older_q[x][i] <= survive[x] | (wr_en[x] & (wr_lane[x] < wr_lane[i]));
                    else if (wr_en[x])
                        older_q[x][i] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rs_aged.sv
// Directed bench for rs_aged: an age-ordered queue model checks every cycle,
// and literal expectations pin the key scenarios.
module tb_rs_aged;
    localparam int RS_DEPTH = 16;
    localparam int DISP_W   = 2;
    localparam int CDB_W    = 2;
    localparam int NUM_FU   = 4;
    localparam int TAG_W    = 6;
    localparam int BR_W     = 4;
    localparam int PLD_W    = 64;
    localparam int FU_W     = 2;
    localparam int CNT_W    = 5;

    logic                         clock, reset;
    logic [DISP_W-1:0]            disp_valid;
    logic [DISP_W-1:0][TAG_W-1:0] disp_tag1, disp_tag2;
    logic [DISP_W-1:0]            disp_rdy1, disp_rdy2;
    logic [DISP_W-1:0][FU_W-1:0]  disp_fu;
    logic [DISP_W-1:0][BR_W-1:0]  disp_brmask;
    logic [DISP_W-1:0][PLD_W-1:0] disp_pld;
    logic [CDB_W-1:0]             cdb_valid;
    logic [CDB_W-1:0][TAG_W-1:0]  cdb_tag;
    logic [NUM_FU-1:0]            issue_stall;
    logic                         br_valid, br_mispred;
    logic [BR_W-1:0]              br_bit;
    logic [NUM_FU-1:0]            issue_valid;
    logic [NUM_FU-1:0][PLD_W-1:0] issue_pld;
    logic [NUM_FU-1:0][BR_W-1:0]  issue_brmask;
    logic [CNT_W-1:0]             free_cnt;
    logic                         full, disp_overflow;

    rs_aged #(
        .RS_DEPTH(RS_DEPTH), .DISP_W(DISP_W), .CDB_W(CDB_W), .NUM_FU(NUM_FU),
        .TAG_W(TAG_W), .BR_W(BR_W), .PLD_W(PLD_W)
    ) dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
        .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2), .disp_fu(disp_fu),
        .disp_brmask(disp_brmask), .disp_pld(disp_pld),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .issue_stall(issue_stall),
        .br_valid(br_valid), .br_bit(br_bit), .br_mispred(br_mispred),
        .issue_valid(issue_valid), .issue_pld(issue_pld), .issue_brmask(issue_brmask),
        .free_cnt(free_cnt), .full(full), .disp_overflow(disp_overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: entries kept oldest-first in a queue; slots and age bits are not modelled.
    typedef struct {
        logic [TAG_W-1:0] tag1, tag2;
        logic             rdy1, rdy2;
        logic [FU_W-1:0]  fu;
        logic [BR_W-1:0]  br;
        logic [PLD_W-1:0] pld;
    } ent_t;

    ent_t              mq[$];
    ent_t              nq[$];
    ent_t              e;
    bit                live = 1'b0;
    bit                granted, exp_ovf;
    int                gsel [NUM_FU];
    int                room;
    logic [NUM_FU-1:0] exp_v;
    logic [BR_W-1:0]   clr;

    function automatic bit hit(input logic [TAG_W-1:0] t);
        for (int c = 0; c < CDB_W; c++)
            if (cdb_valid[c] && cdb_tag[c] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit killed(input logic [BR_W-1:0] m);
        return br_valid && br_mispred && ((m & br_bit) != '0);
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            mq.delete();
            live = 1'b1;
        end else if (live) begin
            clr = (br_valid && !br_mispred) ? br_bit : '0;
            check("free_cnt", free_cnt, RS_DEPTH - mq.size());
            check("full", full, mq.size() == RS_DEPTH);
            exp_v = '0;
            for (int k = 0; k < NUM_FU; k++) begin
                gsel[k] = -1;
                if (!issue_stall[k])
                    for (int n = 0; n < mq.size(); n++) begin
                        e = mq[n];
                        if (!killed(e.br) && (e.rdy1 || hit(e.tag1)) && (e.rdy2 || hit(e.tag2)) &&
                            e.fu == FU_W'(k)) begin
                            gsel[k]  = n;
                            exp_v[k] = 1'b1;
                            break;
                        end
                    end
            end
            check("issue_valid", issue_valid, exp_v);
            for (int k = 0; k < NUM_FU; k++)
                if (gsel[k] >= 0) begin
                    check($sformatf("issue_pld[%0d]", k), issue_pld[k], mq[gsel[k]].pld);
                    check($sformatf("issue_brmask[%0d]", k), issue_brmask[k], mq[gsel[k]].br & ~clr);
                end
            nq.delete();
            for (int n = 0; n < mq.size(); n++) begin
                e = mq[n];
                granted = 1'b0;
                for (int k = 0; k < NUM_FU; k++)
                    if (gsel[k] == n) granted = 1'b1;
                if (!killed(e.br) && !granted) begin
                    e.rdy1 = e.rdy1 | hit(e.tag1);
                    e.rdy2 = e.rdy2 | hit(e.tag2);
                    e.br   = e.br & ~clr;
                    nq.push_back(e);
                end
            end
            room    = RS_DEPTH - mq.size();
            exp_ovf = 1'b0;
            for (int l = 0; l < DISP_W; l++)
                if (disp_valid[l] && !killed(disp_brmask[l])) begin
                    if (room > 0) begin
                        room--;
                        e.tag1 = disp_tag1[l];
                        e.tag2 = disp_tag2[l];
                        e.rdy1 = disp_rdy1[l] | hit(disp_tag1[l]);
                        e.rdy2 = disp_rdy2[l] | hit(disp_tag2[l]);
                        e.fu   = disp_fu[l];
                        e.br   = disp_brmask[l] & ~clr;
                        e.pld  = disp_pld[l];
                        nq.push_back(e);
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
            check("disp_overflow", disp_overflow, exp_ovf);
            mq = nq;
        end
    end

    task automatic idle();
        disp_valid  = '0;
        disp_tag1   = '0;
        disp_tag2   = '0;
        disp_rdy1   = '0;
        disp_rdy2   = '0;
        disp_fu     = '0;
        disp_brmask = '0;
        disp_pld    = '0;
        cdb_valid   = '0;
        cdb_tag     = '0;
        issue_stall = '0;
        br_valid    = 1'b0;
        br_bit      = '0;
        br_mispred  = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic lane(input int l, input logic [TAG_W-1:0] t1, input logic r1,
                        input logic [TAG_W-1:0] t2, input logic r2, input logic [FU_W-1:0] fu,
                        input logic [BR_W-1:0] br, input logic [PLD_W-1:0] pld);
        disp_valid[l]  = 1'b1;
        disp_tag1[l]   = t1;
        disp_rdy1[l]   = r1;
        disp_tag2[l]   = t2;
        disp_rdy2[l]   = r2;
        disp_fu[l]     = fu;
        disp_brmask[l] = br;
        disp_pld[l]    = pld;
    endtask

    task automatic rlane(input int l, input logic [FU_W-1:0] fu, input logic [BR_W-1:0] br,
                         input logic [PLD_W-1:0] pld);
        lane(l, '0, 1'b1, '0, 1'b1, fu, br, pld);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        idle();
        step();
        step();
        step(); reset = 1'b1; #1;
        check("rst_free_cnt", free_cnt, 16);
        check("rst_full", full, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_overflow", disp_overflow, 0);

        // Two ready fu0 ops issue in lane order, one per cycle.
        step(); rlane(0, 0, 0, 'hA0); rlane(1, 0, 0, 'hA1); #1;
        check("s1_no_same_cycle", issue_valid, 0);
        step(); #1;
        check("s1_iv_a", issue_valid, 4'b0001);
        check("s1_pld_a", issue_pld[0], 'hA0);
        check("s1_free14", free_cnt, 14);
        step(); #1;
        check("s1_iv_b", issue_valid, 4'b0001);
        check("s1_pld_b", issue_pld[0], 'hA1);
        check("s1_free15", free_cnt, 15);
        step(); #1;
        check("s1_free16", free_cnt, 16);

        // Different ports issue in the same cycle.
        rlane(0, 0, 0, 'hA2); rlane(1, 1, 0, 'hA3);
        step(); #1;
        check("mp_iv", issue_valid, 4'b0011);
        check("mp_pld0", issue_pld[0], 'hA2);
        check("mp_pld1", issue_pld[1], 'hA3);

        // Wakeup by CDB issues the same cycle; an invalid CDB lane wakes nothing.
        step(); lane(0, 5, 1'b0, 0, 1'b1, 2, 0, 'hB0);
        step(); cdb_valid = 2'b00; cdb_tag[0] = 5; #1;
        check("wk_invalid_cdb", issue_valid, 0);
        check("wk_free15", free_cnt, 15);
        step(); cdb_valid = 2'b01; cdb_tag[0] = 5; #1;
        check("wk_iv", issue_valid, 4'b0100);
        check("wk_pld", issue_pld[2], 'hB0);
        step(); #1;
        check("wk_freed", free_cnt, 16);

        // Sources matching a same-cycle CDB are stored ready.
        lane(0, 7, 1'b0, 8, 1'b0, 3, 0, 'hC0);
        cdb_valid = 2'b11; cdb_tag[0] = 8; cdb_tag[1] = 7;
        step(); #1;
        check("dcdb_iv", issue_valid, 4'b1000);
        check("dcdb_pld", issue_pld[3], 'hC0);

        // Stalled port holds three ops, then drains them oldest first.
        step(); rlane(0, 1, 0, 'hD0); rlane(1, 1, 0, 'hD1);
        step(); rlane(0, 1, 0, 'hD2); issue_stall = 4'b0010; #1;
        check("st_iv0", issue_valid, 0);
        step(); issue_stall = 4'b0010; #1;
        check("st_iv1", issue_valid, 0);
        check("st_free13", free_cnt, 13);
        step(); #1;
        check("st_pld_d0", issue_pld[1], 'hD0);
        step(); #1;
        check("st_pld_d1", issue_pld[1], 'hD1);
        step(); #1;
        check("st_pld_d2", issue_pld[1], 'hD2);
        step(); #1;
        check("st_free16", free_cnt, 16);

        // Mispredict squashes entries and same-cycle lanes; correct prediction clears the bit.
        lane(0, 9, 1'b0, 0, 1'b1, 0, 4'b0001, 'hE0);
        lane(1, 10, 1'b0, 0, 1'b1, 0, 4'b0010, 'hE1);
        step(); br_valid = 1'b1; br_mispred = 1'b1; br_bit = 4'b0001;
        rlane(0, 0, 4'b0001, 'hE2); rlane(1, 3, 4'b0100, 'hE3); #1;
        check("br_iv", issue_valid, 0);
        check("br_no_ovf", disp_overflow, 0);
        check("br_free14", free_cnt, 14);
        step(); #1;
        check("br_e3_iv", issue_valid, 4'b1000);
        check("br_e3_pld", issue_pld[3], 'hE3);
        check("br_e3_mask", issue_brmask[3], 4'b0100);
        step(); br_valid = 1'b1; br_mispred = 1'b0; br_bit = 4'b0010; #1;
        check("br_clr_iv", issue_valid, 0);
        check("br_free15", free_cnt, 15);
        step(); cdb_valid = 2'b11; cdb_tag[0] = 9; cdb_tag[1] = 10; #1;
        check("br_e1_iv", issue_valid, 4'b0001);
        check("br_e1_pld", issue_pld[0], 'hE1);
        check("br_e1_mask", issue_brmask[0], 4'b0000);
        step(); #1;
        check("br_free16", free_cnt, 16);

        // Mispredict masks a ready issue; a same-cycle clear shows on issue_brmask.
        rlane(0, 0, 4'b0100, 'hF0); rlane(1, 1, 4'b1000, 'hF1);
        step(); br_valid = 1'b1; br_mispred = 1'b1; br_bit = 4'b0100; #1;
        check("sq_iv", issue_valid, 4'b0010);
        check("sq_pld", issue_pld[1], 'hF1);
        check("sq_mask", issue_brmask[1], 4'b1000);
        step(); #1;
        check("sq_free16", free_cnt, 16);
        rlane(0, 2, 4'b1000, 'hF2);
        step(); br_valid = 1'b1; br_mispred = 1'b0; br_bit = 4'b1000; #1;
        check("clr_iv", issue_valid, 4'b0100);
        check("clr_pld", issue_pld[2], 'hF2);
        check("clr_mask", issue_brmask[2], 4'b0000);

        // Fill to capacity; extra lanes overflow and existing entries drain untouched.
        for (int c = 0; c < 7; c++) begin
            step();
            lane(0, 20, 1'b0, 0, 1'b1, 0, 0, 'h100 + 2 * c);
            lane(1, 20, 1'b0, 0, 1'b1, 0, 0, 'h101 + 2 * c);
        end
        step(); lane(0, 20, 1'b0, 0, 1'b1, 0, 0, 'h10E);
        step(); lane(0, 20, 1'b0, 0, 1'b1, 0, 0, 'h10F); rlane(1, 0, 0, 'h1FF); #1;
        check("fl_partial_ovf", disp_overflow, 1);
        check("fl_free1", free_cnt, 1);
        step(); rlane(0, 0, 0, 'h1FE); rlane(1, 0, 0, 'h1FD); #1;
        check("fl_ovf", disp_overflow, 1);
        check("fl_full", full, 1);
        check("fl_free0", free_cnt, 0);
        step(); cdb_valid = 2'b01; cdb_tag[0] = 20; rlane(0, 0, 0, 'h1FC); #1;
        check("fl_first_pld", issue_pld[0], 'h100);
        check("fl_no_reuse_ovf", disp_overflow, 1);
        check("fl_still_full", full, 1);
        for (int n = 1; n < 16; n++) begin
            step(); #1;
            check("fl_drain_pld", issue_pld[0], 'h100 + n);
        end
        step(); #1;
        check("fl_empty", free_cnt, 16);

        // Reset mid-operation discards entries and same-cycle dispatch/wakeup.
        lane(0, 30, 1'b0, 0, 1'b1, 1, 0, 'h300);
        lane(1, 31, 1'b0, 0, 1'b1, 2, 0, 'h301);
        step(); reset = 1'b0; rlane(0, 0, 0, 'h302); cdb_valid = 2'b01; cdb_tag[0] = 30;
        step(); reset = 1'b1; #1;
        check("mr_free16", free_cnt, 16);
        check("mr_iv", issue_valid, 0);
        step(); cdb_valid = 2'b11; cdb_tag[0] = 30; cdb_tag[1] = 31; #1;
        check("mr_no_wake", issue_valid, 0);
        step(); #1;
        check("mr_empty", free_cnt, 16);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rs_aged.md
RS_AGED -- requirements
Module: rs_aged

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 16: number of entries (power of 2, 4..64).
REQ-002 SHALL have parameter DISP_W, default 2: dispatch lanes per cycle.
REQ-003 SHALL have parameter CDB_W, default 2: completion broadcast lanes.
REQ-004 SHALL have parameter NUM_FU, default 4: issue ports; port k serves fu_type==k.
REQ-005 SHALL have parameter TAG_W, default 6: physical tag width.
REQ-006 SHALL have parameter BR_W, default 4: branch-mask width.
REQ-007 SHALL have parameter PLD_W, default 64: opaque payload width.
REQ-008 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-009 SHALL have port reset, input, 1: synchronous, active-low.
REQ-010 SHALL have disp_valid, input, DISP_W: lane valid; lane 0 oldest.
REQ-011 SHALL have disp_tag1/disp_tag2, input, DISP_W x TAG_W: source tags.
REQ-012 SHALL have disp_rdy1/disp_rdy2, input, DISP_W: source already available.
REQ-013 SHALL have disp_fu, input, DISP_W x clog2(NUM_FU): target port.
REQ-014 SHALL have disp_brmask, input, DISP_W x BR_W: unresolved branches the op depends on.
REQ-015 SHALL have disp_pld, input, DISP_W x PLD_W: carried unmodified to issue.
REQ-016 SHALL have cdb_valid, input, CDB_W; cdb_tag, input, CDB_W x TAG_W: wakeup broadcasts.
REQ-017 SHALL have issue_stall, input, NUM_FU: port cannot accept.
REQ-018 SHALL have br_valid, input, 1; br_bit, input, BR_W one-hot; br_mispred, input, 1: branch resolution.
REQ-019 SHALL have issue_valid, output, NUM_FU; issue_pld, output, NUM_FU x PLD_W; issue_brmask, output, NUM_FU x BR_W.
REQ-020 SHALL have free_cnt, output, clog2(RS_DEPTH)+1: free entries in current state.
REQ-021 SHALL have full, output, 1: free_cnt==0.
REQ-022 SHALL have disp_overflow, output, 1: one-cycle pulse, valid lane dropped for lack of space.

Function
REQ-023 Entry state: busy, rdy1, rdy2, tag1, tag2, fu, brmask, pld, plus RS_DEPTH x RS_DEPTH age matrix older[i][j].
REQ-024 Dispatch: valid lanes in lane order take free slots (busy==0 in current state) lowest index first; slots freed by issue this cycle not reusable until next cycle.
REQ-025 Valid lanes beyond free_cnt dropped, disp_overflow=1 that cycle; accepted lanes unaffected.
REQ-026 On write into slot i: older[j][i]=1 for every busy surviving j and every lower-lane slot written same cycle; older[i][*]=0.
REQ-027 Wakeup: source ready when rdy bit set or tag equals any valid cdb_tag this cycle; registered rdy bit set same edge.
REQ-028 Dispatched source matching a same-cycle CDB tag stored ready.
REQ-029 Issue port k, not stalled: grant busy, both-ready entry with fu==k having no older candidate for k; issue_valid/pld/brmask combinational same cycle; granted entry busy=0 next edge.
REQ-030 Stalled port: issue_valid=0, no entry removed, age order kept.
REQ-031 Earliest issue: cycle after dispatch; latency dispatch->issue 1 cycle minimum.
REQ-032 br_valid & br_mispred: entries with brmask&br_bit!=0 busy=0 next edge, issue_valid masked for them this cycle; same-cycle dispatch lanes with that bit dropped (no disp_overflow).
REQ-033 br_valid & !br_mispred: bit cleared from every entry brmask and every accepted lane brmask; issue_brmask shows cleared value.
REQ-034 Squash, wakeup, issue, dispatch all same cycle: squash wins over issue and dispatch; wakeup applies to survivors.
REQ-035 free_cnt and full derived from registered busy only.
REQ-036 Issue grants to distinct ports are independent; one entry never granted to two ports.

Reset
REQ-037 reset==0 at edge: all busy, rdy, brmask, age bits 0; next cycle issue_valid=0, disp_overflow=0, free_cnt=RS_DEPTH, full=0.
REQ-038 Reset mid-operation discards all entries; same-cycle dispatch/wakeup ignored.

Verification
REQ-039 Reset, dispatch 2 lanes fu=0 rdy both -> next cycle issue_valid[0]=1 lane-0 payload, following cycle lane-1 payload; free_cnt 16->14->15->16.
REQ-040 Entry tag1=5 not ready, cdb_tag=5 cycle N -> issue_valid same cycle N, entry freed N+1.
REQ-041 Fill 16 entries, dispatch 2 more -> disp_overflow=1, full=1, no existing entry altered.
REQ-042 Three ready fu=1 entries, issue_stall[1]=1 two cycles then 0 -> issues strictly in dispatch order after release.
REQ-043 Entries brmask 0001/0010, br_valid mispred br_bit=0001 -> first squashed, never issues; non-mispred br_bit=0010 -> second issues brmask 0000.
REQ-044 Mispredict same cycle as ready issue of affected entry -> issue_valid=0, free_cnt rises next cycle.
